lpc_stream_burst_writer: RTL and testbench

Parametrised stream-to-memory write master that replaces the fixed 16-bit write stream path into the DDR3 controller. It packs incoming samples into memory-width words and buffers them in an internal FIFO. It writes them as fixed-length Avalon-MM bursts into a configurable address window, in either one-shot or circular (ring-buffer) mode. It sits between the capture front end and the memory controller's Avalon-MM slave port.

---
 rtl/lpc_stream_burst_writer.sv | 201 ++++++++++++++++++++
 tb/tb_lpc_stream_burst_writer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/lpc_stream_burst_writer.sv
`default_nettype none
// lpc_stream_burst_writer: packs DATA_W samples into MEM_W words, queues them in a FIFO and
// writes fixed-length Avalon-MM bursts into a one-shot or circular address window. Rev 1.0
module lpc_stream_burst_writer #(
    parameter int    DATA_W     = 16,
    parameter int    MEM_W      = 64,
    parameter int    ADDR_W     = 29,
    parameter int    BURST_LEN  = 8,
    parameter int    FIFO_DEPTH = 64,
    parameter longint BASE_ADDR = 0,
    parameter longint SPAN      = 32768,
    parameter int    CIRCULAR   = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 stop,
    input  logic [DATA_W-1:0]    d_in,
    input  logic                 v,
    output logic [ADDR_W-1:0]    avm_address,
    output logic                 avm_write,
    output logic [MEM_W-1:0]     avm_writedata,
    output logic [MEM_W/8-1:0]   avm_byteenable,
    output logic [6:0]           avm_burstcount,
    input  logic                 avm_waitrequest,
    output logic                 busy,
    output logic                 done,
    output logic                 overflow,
    output logic [ADDR_W-1:0]    words_written
);
    localparam int R   = MEM_W / DATA_W;
    localparam int K_W = (R > 1) ? $clog2(R) : 1;
    localparam int P_W = $clog2(FIFO_DEPTH);
    localparam int C_W = P_W + 1;
    localparam logic [ADDR_W-1:0] C_BASE  = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] C_END   = ADDR_W'(BASE_ADDR + SPAN);
    localparam logic [ADDR_W-1:0] C_BYTES = ADDR_W'(BURST_LEN * MEM_W / 8);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_BURST = 3'd2,
        S_ADV   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t             r_state, w_nxt;
    logic [MEM_W-1:0]   mem [FIFO_DEPTH];
    logic [P_W-1:0]     r_wr_ptr, r_rd_ptr;
    logic [C_W-1:0]     r_count;
    logic [K_W-1:0]     r_lane;
    logic [MEM_W-1:0]   r_pack, w_word;
    logic [6:0]         r_beat;
    logic               r_stop_pend, r_start_pend;
    logic               w_armed, w_accept, w_last, w_full, w_push_req, w_push;
    logic               w_restart, w_discard, w_flush;
    logic [ADDR_W-1:0]  w_next_addr;

    assign avm_byteenable = '1;
    assign avm_burstcount = 7'(BURST_LEN);

    assign w_armed     = (r_state == S_FILL) || (r_state == S_BURST) || (r_state == S_ADV);
    assign w_accept    = avm_write && !avm_waitrequest;
    assign w_last      = w_accept && (r_beat == 7'(BURST_LEN - 1));
    assign w_next_addr = avm_address + C_BYTES;
    assign w_full      = (r_count == C_W'(FIFO_DEPTH));
    assign w_flush     = w_restart || w_discard;
    assign w_push_req  = w_armed && v && !w_flush && (r_lane == K_W'(R - 1));
    // A pop on the same edge frees a slot, so a full FIFO can still accept the push.
    assign w_push      = w_push_req && (!w_full || w_accept);

    always_comb begin
        w_word = r_pack;
        w_word[r_lane*DATA_W +: DATA_W] = d_in;
    end

    always_comb begin
        w_nxt     = r_state;
        w_restart = 1'b0;
        w_discard = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_nxt     = S_FILL;
                    w_restart = 1'b1;
                end
            end
            S_FILL: begin
                if (start) begin
                    w_restart = 1'b1;
                end else if (stop) begin
                    w_nxt     = S_IDLE;
                    w_discard = 1'b1;
                end else if (r_count >= C_W'(BURST_LEN)) begin
                    w_nxt = S_BURST;
                end
            end
            S_BURST: begin
                if (w_last) w_nxt = S_ADV;
            end
            S_ADV: begin
                if (start || r_start_pend) begin
                    w_nxt     = S_FILL;
                    w_restart = 1'b1;
                end else if (w_next_addr == C_END && CIRCULAR == 0) begin
                    w_nxt     = S_DONE;
                    w_discard = 1'b1;
                end else if (stop || r_stop_pend) begin
                    w_nxt     = S_IDLE;
                    w_discard = 1'b1;
                end else begin
                    w_nxt = S_FILL;
                end
            end
            default: w_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) mem[r_wr_ptr] <= w_word;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            avm_write     <= 1'b0;
            avm_writedata <= '0;
            avm_address   <= C_BASE;
            busy          <= 1'b0;
            done          <= 1'b0;
            overflow      <= 1'b0;
            words_written <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_lane        <= '0;
            r_pack        <= '0;
            r_beat        <= '0;
            r_stop_pend   <= 1'b0;
            r_start_pend  <= 1'b0;
        end else begin
            r_state <= w_nxt;
            busy    <= (w_nxt == S_FILL) || (w_nxt == S_BURST) || (w_nxt == S_ADV);
            done    <= (w_nxt == S_DONE);

            if (w_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
                r_lane   <= '0;
                r_pack   <= '0;
            end else begin
                if (w_push)   r_wr_ptr <= r_wr_ptr + P_W'(1);
                if (w_accept) r_rd_ptr <= r_rd_ptr + P_W'(1);
                r_count <= r_count + C_W'(w_push) - C_W'(w_accept);
                if (w_armed && v) begin
                    if (r_lane == K_W'(R - 1)) begin
                        r_lane <= '0;
                        r_pack <= '0;
                    end else begin
                        r_lane <= r_lane + K_W'(1);
                        r_pack <= w_word;
                    end
                end
            end

            if (w_restart) begin
                avm_address   <= C_BASE;
                words_written <= '0;
                overflow      <= 1'b0;
            end else begin
                if (r_state == S_ADV)
                    avm_address <= (w_next_addr == C_END && CIRCULAR != 0) ? C_BASE : w_next_addr;
                if (w_accept && words_written != {ADDR_W{1'b1}})
                    words_written <= words_written + ADDR_W'(1);
                if (w_push_req && w_full && !w_accept)
                    overflow <= 1'b1;
            end

            // Requests arriving mid-burst are held until the burst has been fully issued.
            if (w_restart || r_state == S_ADV) begin
                r_stop_pend  <= 1'b0;
                r_start_pend <= 1'b0;
            end else if (r_state == S_BURST) begin
                if (stop)  r_stop_pend  <= 1'b1;
                if (start) r_start_pend <= 1'b1;
            end

            if (r_state == S_FILL && w_nxt == S_BURST) begin
                avm_write     <= 1'b1;
                avm_writedata <= mem[r_rd_ptr];
                r_beat        <= '0;
            end else if (w_accept) begin
                r_beat <= r_beat + 7'd1;
                if (w_last) avm_write     <= 1'b0;
                else        avm_writedata <= mem[r_rd_ptr + P_W'(1)];
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_lpc_stream_burst_writer.sv
`default_nettype none
// tb_lpc_stream_burst_writer: one-shot and circular instances driven side by side and
// checked beat by beat against a queue-based model of the packed sample stream. Rev 1.0
module tb_lpc_stream_burst_writer;
    localparam int DW = 16, MW = 64, AW = 29, BL = 4, DEPTH = 16, R = MW / DW;
    localparam logic [AW-1:0] BASE = 29'h1000, WEND = 29'h1080, STEP = 29'h20;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, start, stop, v, wait_r;
    logic [DW-1:0] d_in;
    logic [AW-1:0] addr [2];
    logic          wr [2];
    logic [MW-1:0] wdata [2];
    logic [7:0]    be [2];
    logic [6:0]    bc [2];
    logic          busy [2], done [2], ovf [2];
    logic [AW-1:0] ww [2];

    lpc_stream_burst_writer #(.DATA_W(DW), .MEM_W(MW), .ADDR_W(AW), .BURST_LEN(BL),
        .FIFO_DEPTH(DEPTH), .BASE_ADDR(64'h1000), .SPAN(64'h80), .CIRCULAR(0)) dut0 (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .d_in(d_in), .v(v),
        .avm_address(addr[0]), .avm_write(wr[0]), .avm_writedata(wdata[0]),
        .avm_byteenable(be[0]), .avm_burstcount(bc[0]), .avm_waitrequest(wait_r),
        .busy(busy[0]), .done(done[0]), .overflow(ovf[0]), .words_written(ww[0]));

    lpc_stream_burst_writer #(.DATA_W(DW), .MEM_W(MW), .ADDR_W(AW), .BURST_LEN(BL),
        .FIFO_DEPTH(DEPTH), .BASE_ADDR(64'h1000), .SPAN(64'h80), .CIRCULAR(1)) dut1 (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .d_in(d_in), .v(v),
        .avm_address(addr[1]), .avm_write(wr[1]), .avm_writedata(wdata[1]),
        .avm_byteenable(be[1]), .avm_burstcount(bc[1]), .avm_waitrequest(wait_r),
        .busy(busy[1]), .done(done[1]), .overflow(ovf[1]), .words_written(ww[1]));

    int n_total = 0, n_bad = 0;

    // Reference model: expected FIFO contents as a ring of words, plus window bookkeeping.
    logic [MW-1:0] mq [2][DEPTH];
    int            mhead [2], msize [2], m_lane [2], m_beat [2], m_ww [2], m_bursts [2];
    logic          m_armed [2], m_done [2], m_ovf [2], m_pend [2];
    logic [MW-1:0] m_part [2], first_beat [2];
    logic [AW-1:0] m_addr [2];
    logic [AW-1:0] blog [2][8];
    logic          held [2];
    logic [AW-1:0] held_a [2];
    logic [MW-1:0] held_d [2];

    logic          c_wr [2];
    logic [AW-1:0] c_addr [2];
    logic [MW-1:0] c_data [2];
    logic          c_reset, c_start, c_stop, c_v, c_wait;
    logic [DW-1:0] c_d;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic model_flush(input int i);
        mhead[i] = 0; msize[i] = 0; m_lane[i] = 0; m_part[i] = '0;
    endtask

    task automatic model_step(input int i);
        logic          acc;
        logic [MW-1:0] w;
        if (c_reset) begin
            model_flush(i);
            m_armed[i] = 0; m_done[i] = 0; m_ovf[i] = 0; m_pend[i] = 0; held[i] = 0;
            m_beat[i] = 0; m_ww[i] = 0; m_bursts[i] = 0; m_addr[i] = BASE;
            return;
        end
        if (held[i] && c_wr[i]) begin
            chk($sformatf("stable_addr[%0d]", i), 64'(c_addr[i]), 64'(held_a[i]));
            chk($sformatf("stable_data[%0d]", i), c_data[i], held_d[i]);
        end
        held[i] = c_wr[i] && c_wait; held_a[i] = c_addr[i]; held_d[i] = c_data[i];
        if (c_start) begin
            model_flush(i);
            m_armed[i] = 1; m_done[i] = 0; m_ovf[i] = 0; m_pend[i] = 0;
            m_beat[i] = 0; m_ww[i] = 0; m_bursts[i] = 0; m_addr[i] = BASE;
            return;
        end
        acc = c_wr[i] && !c_wait;
        if (acc) begin
            if (!m_armed[i] || msize[i] == 0) begin
                chk($sformatf("unexpected_beat[%0d]", i), 64'd1, 64'd0);
            end else begin
                if (m_beat[i] == 0) begin
                    chk($sformatf("burst_addr[%0d]", i), 64'(c_addr[i]), 64'(m_addr[i]));
                    if (m_bursts[i] < 8) blog[i][m_bursts[i]] = c_addr[i];
                end
                if (m_ww[i] == 0) first_beat[i] = c_data[i];
                chk($sformatf("beat_data[%0d]", i), c_data[i], mq[i][mhead[i]]);
                mhead[i] = (mhead[i] + 1) % DEPTH; msize[i]--; m_ww[i]++; m_beat[i]++;
                if (m_beat[i] == BL) begin
                    m_beat[i] = 0; m_bursts[i]++; m_addr[i] += STEP;
                    if (m_addr[i] == WEND) begin
                        if (i == 1) m_addr[i] = BASE;
                        else begin m_armed[i] = 0; m_done[i] = 1; model_flush(i); end
                    end
                    if (m_pend[i]) begin m_pend[i] = 0; m_armed[i] = 0; model_flush(i); end
                end
            end
        end
        if (c_stop && m_armed[i]) begin
            if (m_beat[i] > 0) m_pend[i] = 1;
            else begin m_armed[i] = 0; model_flush(i); end
        end
        if (m_armed[i] && c_v) begin
            w = m_part[i];
            w[m_lane[i]*DW +: DW] = c_d;
            if (m_lane[i] == R - 1) begin
                m_lane[i] = 0; m_part[i] = '0;
                if (msize[i] == DEPTH) m_ovf[i] = 1;
                else begin mq[i][(mhead[i] + msize[i]) % DEPTH] = w; msize[i]++; end
            end else begin
                m_part[i] = w; m_lane[i]++;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            c_wr[i] = wr[i]; c_addr[i] = addr[i]; c_data[i] = wdata[i];
        end
        c_reset = reset; c_start = start; c_stop = stop; c_v = v; c_wait = wait_r; c_d = d_in;
        @(posedge clk);
        #1;
        model_step(0);
        model_step(1);
    endtask

    task automatic cyc(input logic iv, input logic [DW-1:0] id, input logic ist,
                       input logic isp, input logic iw);
        v = iv; d_in = id; start = ist; stop = isp; wait_r = iw;
        tick();
    endtask

    initial begin
        int  sent, guard;
        logic go, stop_sent, sp;
        reset = 1; start = 0; stop = 0; v = 0; d_in = '0; wait_r = 0;
        repeat (3) tick();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_write[%0d]", i), 64'(wr[i]), 64'd0);
            chk($sformatf("rst_addr[%0d]", i), 64'(addr[i]), 64'h1000);
            chk($sformatf("rst_data[%0d]", i), wdata[i], 64'd0);
            chk($sformatf("rst_busy[%0d]", i), 64'(busy[i]), 64'd0);
            chk($sformatf("rst_done[%0d]", i), 64'(done[i]), 64'd0);
            chk($sformatf("rst_ovf[%0d]", i), 64'(ovf[i]), 64'd0);
            chk($sformatf("rst_ww[%0d]", i), 64'(ww[i]), 64'd0);
            chk($sformatf("burstcount[%0d]", i), 64'(bc[i]), 64'd4);
            chk($sformatf("byteenable[%0d]", i), 64'(be[i]), 64'hff);
        end
        reset = 0;

        // Ascending samples: one burst with a known first beat
        cyc(0, '0, 1, 0, 0);
        for (int k = 1; k <= 16; k++) cyc(1, DW'(k), 0, 0, 0);
        repeat (20) cyc(0, '0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("s1_ww[%0d]", i), 64'(ww[i]), 64'd4);
            chk($sformatf("s1_first_beat[%0d]", i), first_beat[i], 64'h0004_0003_0002_0001);
            chk($sformatf("s1_addr[%0d]", i), 64'(blog[i][0]), 64'h1000);
        end

        // 80 random samples with gaps and random stalls: window fill vs wrap
        cyc(0, '0, 1, 0, 0);
        sent = 0; guard = 0;
        while (sent < 80 && guard < 400) begin
            go = ($urandom_range(3) != 0);
            cyc(go, DW'($urandom), 0, 0, $urandom_range(3) == 0);
            if (go) sent++;
            guard++;
        end
        repeat (40) cyc(0, '0, 0, 0, 0);
        chk("s2_ww_oneshot", 64'(ww[0]), 64'd16);
        chk("s2_done_oneshot", 64'(done[0]), 64'd1);
        chk("s2_busy_oneshot", 64'(busy[0]), 64'd0);
        chk("s2_last_addr_oneshot", 64'(blog[0][3]), 64'h1060);
        chk("s3_ww_circ", 64'(ww[1]), 64'd20);
        chk("s3_busy_circ", 64'(busy[1]), 64'd1);
        chk("s3_done_circ", 64'(done[1]), 64'd0);
        chk("s3_wrap_addr_circ", 64'(blog[1][4]), 64'h1000);

        // Long stall with continuous input: overflow, held beat, lossless drain
        cyc(0, '0, 1, 0, 0);
        repeat (100) cyc(1, DW'($urandom), 0, 0, 1);
        repeat (60) cyc(0, '0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("s4_ovf[%0d]", i), 64'(ovf[i]), 64'd1);
            chk($sformatf("s4_ovf_model[%0d]", i), 64'(ovf[i]), 64'(m_ovf[i]));
            chk($sformatf("s4_ww[%0d]", i), 64'(ww[i]), 64'd16);
        end
        chk("s4_done_oneshot", 64'(done[0]), 64'd1);

        // Stop during the second beat of the first burst
        cyc(0, '0, 1, 0, 0);
        stop_sent = 0;
        for (int k = 0; k < 60; k++) begin
            sp = (m_beat[0] == 1) && !stop_sent;
            if (sp) stop_sent = 1;
            cyc(k < 32, DW'($urandom), 0, sp, 0);
        end
        chk("s5_stop_issued", 64'(stop_sent), 64'd1);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("s5_ww[%0d]", i), 64'(ww[i]), 64'd4);
            chk($sformatf("s5_busy[%0d]", i), 64'(busy[i]), 64'd0);
        end
        repeat (8) cyc(1, DW'($urandom), 0, 0, 0);
        repeat (20) cyc(0, '0, 0, 0, 0);
        for (int i = 0; i < 2; i++)
            chk($sformatf("s5_ww_after[%0d]", i), 64'(ww[i]), 64'd4);

        // Reset while a stalled burst is on the bus
        cyc(0, '0, 1, 0, 0);
        for (int k = 0; k < 16; k++) cyc(1, DW'($urandom), 0, 0, 1);
        for (int k = 0; k < 40 && !wr[0]; k++) cyc(0, '0, 0, 0, 1);
        chk("s5_burst_pending", 64'(wr[0]), 64'd1);
        reset = 1;
        cyc(0, '0, 0, 0, 1);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("s5_rst_write[%0d]", i), 64'(wr[i]), 64'd0);
            chk($sformatf("s5_rst_addr[%0d]", i), 64'(addr[i]), 64'h1000);
            chk($sformatf("s5_rst_busy[%0d]", i), 64'(busy[i]), 64'd0);
            chk($sformatf("s5_rst_ww[%0d]", i), 64'(ww[i]), 64'd0);
        end
        reset = 0;
        repeat (4) cyc(0, '0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
